// File: rtl/lisp_mem_pkg.sv
// Shared types and constants for the memory arbiter slice: bus widths,
// arbiter FSM states and the latched transaction record.
package lisp_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        WAIT_WR,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              id;
    } mem_txn_t;

    // Allocated addresses are returned to the requester on the data bus.
    function automatic logic [DATA_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
        return {{(DATA_W - ADDR_W){1'b0}}, a};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A sole requester always wins; on contention the
// port named by the pointer wins, and the pointer flips away from each winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_id
);

    logic rr_ptr;

    // Pointer moves to the loser only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (advance && grant_valid) begin
            rr_ptr <= ~grant_id;
        end
    end

    // Grant selection from the current request pair and the pointer.
    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11) begin
            grant_id = rr_ptr;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port allocate-on-write
// memory. Port 0 is the evaluator, port 1 the cons/GC unit. One transaction
// is in flight at a time: IDLE -> ISSUE -> WAIT_RD/WAIT_WR -> RESP -> IDLE.
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound the read wait to
// TIMEOUT_CYCLES cycles, reporting resp_err=1 and all-ones data on expiry.
module mem_arbiter #(
    parameter int ADDR_W = lisp_mem_pkg::ADDR_W,
    parameter int DATA_W = lisp_mem_pkg::DATA_W
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_ready,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [ADDR_W-1:0] mem_write_result_addr
);

    import lisp_mem_pkg::*;

    arb_state_t state;
    arb_state_t state_next;
    mem_txn_t   txn;
    logic       grant_valid;
    logic       grant_id;
    logic       accept;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       timed_out;
`endif

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req         ({req1_valid, req0_valid}),
        .advance     (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign mem_addr  = txn.addr;
    assign mem_wdata = txn.wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the one-cycle ready, strobe and response pulses.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && !rst) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req    = ~txn.we;
                mem_we     = txn.we;
                state_next = txn.we ? WAIT_WR : WAIT_RD;
            end
            WAIT_RD: begin
                if (mem_data_ready) begin
                    state_next = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (timed_out) begin
                    state_next = RESP;
`endif
                end
            end
            WAIT_WR: begin
                state_next = RESP;
            end
            RESP: begin
                resp0_valid = ~txn.id;
                resp1_valid = txn.id;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction latch on accept, and response data capture from memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn       <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        txn.id    <= grant_id;
                        txn.we    <= grant_id ? req1_we    : req0_we;
                        txn.addr  <= grant_id ? req1_addr  : req0_addr;
                        txn.wdata <= grant_id ? req1_wdata : req0_wdata;
                    end
                end
                WAIT_RD: begin
                    if (mem_data_ready) begin
                        resp_data <= mem_data_out;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (timed_out) begin
                        resp_data <= '1;
`endif
                    end
                end
                WAIT_WR: begin
                    resp_data <= zext_addr(mem_write_result_addr);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Read-wait counter: restarts as WAIT_RD is entered, advances each waiting cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT_RD) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timed_out = (state == WAIT_RD) && (wait_cnt == TIMEOUT_LAST);

    // Error flag: raised by an expired read, cleared by any normal completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (state == WAIT_RD) begin
            if (mem_data_ready) begin
                resp_err <= 1'b0;
            end else if (timed_out) begin
                resp_err <= 1'b1;
            end
        end else if (state == WAIT_WR) begin
            resp_err <= 1'b0;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single write, delayed read, idle
// memory noise, round-robin contention, reset mid-read, and (when
// MEM_ARB_TIMEOUT_EN is defined) the read timeout with TIMEOUT_CYCLES=8.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_we, req0_ready;
    logic [11:0] req0_addr;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [11:0] req1_addr;
    logic [15:0] req1_wdata;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_ready;
    logic [15:0] mem_data_out;
    logic [11:0] mem_write_result_addr;

    int vectors;
    int miscompares;

    mem_arbiter #(
        .ADDR_W (12),
        .DATA_W (16)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req0_valid            (req0_valid),
        .req0_we               (req0_we),
        .req0_addr             (req0_addr),
        .req0_wdata            (req0_wdata),
        .req0_ready            (req0_ready),
        .req1_valid            (req1_valid),
        .req1_we               (req1_we),
        .req1_addr             (req1_addr),
        .req1_wdata            (req1_wdata),
        .req1_ready            (req1_ready),
        .resp0_valid           (resp0_valid),
        .resp1_valid           (resp1_valid),
        .resp_data             (resp_data),
        .resp_err              (resp_err),
        .mem_req               (mem_req),
        .mem_addr              (mem_addr),
        .mem_we                (mem_we),
        .mem_wdata             (mem_wdata),
        .mem_data_ready        (mem_data_ready),
        .mem_data_out          (mem_data_out),
        .mem_write_result_addr (mem_write_result_addr)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic we0, input logic [11:0] a0,
                                 input logic [15:0] d0, input logic v1, input logic we1,
                                 input logic [11:0] a1, input logic [15:0] d1);
        req0_valid = v0;
        req0_we    = we0;
        req0_addr  = a0;
        req0_wdata = d0;
        req1_valid = v1;
        req1_we    = we1;
        req1_addr  = a1;
        req1_wdata = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; expected values are hand-derived from the cycle timing.
    initial begin
        int rem0;
        int rem1;
        int seen0;
        int seen1;
        logic exp_id;
        logic [15:0] exp_wdata;

        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        mem_data_ready = 1'b0;
        mem_data_out   = 16'h0000;
        mem_write_result_addr = 12'h001;
        applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_ready0", req0_ready, 0);
        checkOutput("rst_ready1", req1_ready, 0);
        checkOutput("rst_resp0", resp0_valid, 0);
        checkOutput("rst_resp1", resp1_valid, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_resp_data", resp_data, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        $display("[TB] single write from port 0");
        applyStimulus(1, 1, 12'h000, 16'hBEEF, 0, 0, 12'h000, 16'h0000);
        checkOutput("wr_ready0", req0_ready, 1);
        checkOutput("wr_ready1", req1_ready, 0);
        tick();
        applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("wr_mem_we", mem_we, 1);
        checkOutput("wr_mem_req", mem_req, 0);
        checkOutput("wr_mem_wdata", mem_wdata, 16'hBEEF);
        checkOutput("wr_resp0_early", resp0_valid, 0);
        tick();
        checkOutput("wr_mem_we_drop", mem_we, 0);
        checkOutput("wr_resp0_t2", resp0_valid, 0);
        tick();
        checkOutput("wr_resp0", resp0_valid, 1);
        checkOutput("wr_resp1", resp1_valid, 0);
        checkOutput("wr_resp_data", resp_data, 16'h0001);
        checkOutput("wr_resp_err", resp_err, 0);
        tick();
        checkOutput("wr_resp0_after", resp0_valid, 0);

        $display("[TB] delayed read from port 1");
        applyStimulus(0, 0, 12'h000, 16'h0000, 1, 0, 12'h002, 16'h0000);
        checkOutput("rd_ready1", req1_ready, 1);
        checkOutput("rd_ready0", req0_ready, 0);
        tick();
        applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("rd_mem_req", mem_req, 1);
        checkOutput("rd_mem_we", mem_we, 0);
        checkOutput("rd_mem_addr", mem_addr, 12'h002);
        tick();
        checkOutput("rd_mem_req_drop", mem_req, 0);
        checkOutput("rd_mem_addr_hold", mem_addr, 12'h002);
        checkOutput("rd_resp1_wait1", resp1_valid, 0);
        tick();
        mem_data_ready = 1'b1;
        mem_data_out   = 16'hDEAD;
        checkOutput("rd_resp1_wait2", resp1_valid, 0);
        tick();
        mem_data_ready = 1'b0;
        checkOutput("rd_resp1", resp1_valid, 1);
        checkOutput("rd_resp0", resp0_valid, 0);
        checkOutput("rd_resp_data", resp_data, 16'hDEAD);
        checkOutput("rd_resp_err", resp_err, 0);
        tick();
        checkOutput("rd_resp1_once", resp1_valid, 0);
        checkOutput("rd_resp0_after", resp0_valid, 0);

        $display("[TB] memory noise while idle");
        mem_data_ready = 1'b1;
        mem_data_out   = 16'h1234;
        #1;
        checkOutput("noise_resp0", resp0_valid, 0);
        checkOutput("noise_resp1", resp1_valid, 0);
        tick();
        mem_data_ready = 1'b0;
        checkOutput("noise_resp0_next", resp0_valid, 0);
        checkOutput("noise_resp1_next", resp1_valid, 0);
        checkOutput("noise_mem_req", mem_req, 0);
        checkOutput("noise_resp_data_hold", resp_data, 16'hDEAD);

        $display("[TB] contention, three writes per port");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rem0  = 3;
        rem1  = 3;
        seen0 = 0;
        seen1 = 0;
        applyStimulus(1, 1, 12'h000, 16'hA000, 1, 1, 12'h000, 16'hB000);
        for (int k = 0; k < 6; k++) begin
            exp_id    = (k % 2) == 1;
            exp_wdata = exp_id ? 16'hB000 + 16'(3 - rem1) : 16'hA000 + 16'(3 - rem0);
            checkOutput("cont_ready0", req0_ready, !exp_id);
            checkOutput("cont_ready1", req1_ready, exp_id);
            tick();
            mem_write_result_addr = 12'h010 + 12'(k);
            checkOutput("cont_mem_we", mem_we, 1);
            checkOutput("cont_mem_wdata", mem_wdata, exp_wdata);
            tick();
            tick();
            checkOutput("cont_resp0", resp0_valid, !exp_id);
            checkOutput("cont_resp1", resp1_valid, exp_id);
            checkOutput("cont_resp_data", resp_data, 16'h0010 + 16'(k));
            if (resp0_valid) seen0++;
            if (resp1_valid) seen1++;
            if (exp_id) rem1--; else rem0--;
            applyStimulus(rem0 > 0, 1, 12'h000, 16'hA000 + 16'(3 - rem0),
                          rem1 > 0, 1, 12'h000, 16'hB000 + 16'(3 - rem1));
            tick();
        end
        checkOutput("cont_count0", seen0, 3);
        checkOutput("cont_count1", seen1, 3);
        checkOutput("cont_idle_ready0", req0_ready, 0);
        checkOutput("cont_idle_ready1", req1_ready, 0);

        $display("[TB] reset during read wait");
        applyStimulus(1, 0, 12'h005, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("rrst_ready0", req0_ready, 1);
        tick();
        applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("rrst_mem_req", mem_req, 1);
        checkOutput("rrst_mem_addr", mem_addr, 12'h005);
        tick();
        rst = 1'b1;
        checkOutput("rrst_resp0_wait", resp0_valid, 0);
        tick();
        checkOutput("rrst_resp0", resp0_valid, 0);
        checkOutput("rrst_mem_req_drop", mem_req, 0);
        checkOutput("rrst_mem_addr_clr", mem_addr, 0);
        rst = 1'b0;
        tick();
        checkOutput("rrst_resp0_next", resp0_valid, 0);
        checkOutput("rrst_resp1_next", resp1_valid, 0);
        applyStimulus(1, 0, 12'h006, 16'h0000, 1, 0, 12'h007, 16'h0000);
        checkOutput("rrst_grant0", req0_ready, 1);
        checkOutput("rrst_grant1", req1_ready, 0);
        tick();
        applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("rrst_mem_addr2", mem_addr, 12'h006);
        tick();
        mem_data_ready = 1'b1;
        mem_data_out   = 16'h0BAD;
        tick();
        mem_data_ready = 1'b0;
        checkOutput("rrst_resp0_done", resp0_valid, 1);
        checkOutput("rrst_resp_data", resp_data, 16'h0BAD);
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] read timeout");
        applyStimulus(1, 0, 12'h008, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("to_ready0", req0_ready, 1);
        tick();
        applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000);
        checkOutput("to_mem_req", mem_req, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checkOutput("to_resp0_wait", resp0_valid, 0);
        end
        tick();
        checkOutput("to_resp0", resp0_valid, 1);
        checkOutput("to_resp_err", resp_err, 1);
        checkOutput("to_resp_data", resp_data, 16'hFFFF);
        mem_data_ready = 1'b1;
        mem_data_out   = 16'h5555;
        tick();
        checkOutput("to_late_resp0", resp0_valid, 0);
        tick();
        mem_data_ready = 1'b0;
        checkOutput("to_late_resp0_2", resp0_valid, 0);
        checkOutput("to_late_data_hold", resp_data, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port `memory` block (12-bit address, 16-bit data, allocate-on-write).
- Port 0 is the evaluator; port 1 is the cons/GC unit.
- Serialises read and allocate-write transactions with round-robin fairness, drives the memory's req/write_enable strobes, and returns read data or the allocated address to the winning requester.
- One transaction is in flight at a time.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 16, memory data width.
- TIMEOUT_CYCLES, 255, max wait for mem_data_ready. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has a transaction pending; held until its ready pulse.
- req0_we / req1_we  in  1  1 = allocate-write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  read address; ignored for writes.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- req0_ready / req1_ready  out  1  one-cycle accept pulse.
- resp0_valid / resp1_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_W  read data, or {0, allocated address} for writes; valid with respN_valid.
- resp_err  out  1  timeout flag; valid with respN_valid.
- mem_req  out  1  one-cycle read strobe to memory.
- mem_addr  out  ADDR_W  read address to memory.
- mem_we  out  1  one-cycle write strobe to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_data_ready  in  1  memory read data valid.
- mem_data_out  in  DATA_W  memory read data.
- mem_write_result_addr  in  ADDR_W  address allocated by the last write.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: ready, resp_valid, mem_req, mem_we, resp_data, resp_err, mem_addr, mem_wdata.
  - Reset mid-transaction aborts it: no response is produced and the strobes drop on the next edge.
- FSM: IDLE -> ISSUE -> (WAIT_RD | WAIT_WR) -> RESP -> IDLE.
- IDLE:
  - If any reqN_valid, grant: a sole requester wins; if both are valid, the port equal to rr_ptr wins.
  - reqN_ready=1 that cycle (combinational from state and grant).
  - Latch we, addr, wdata and grant id.
  - rr_ptr <= ~winner.
- ISSUE (1 cycle):
  - mem_req=1 if read, mem_we=1 if write.
  - mem_addr and mem_wdata are driven from the latch; they hold through WAIT.
- WAIT_RD:
  - Stay until mem_data_ready=1, then latch mem_data_out.
  - mem_data_ready in any other state is ignored.
- WAIT_WR: exactly 1 cycle; latch zero-extended mem_write_result_addr.
- RESP:
  - resp{grant}_valid=1 for one cycle.
  - resp_data and resp_err hold their values until the next RESP.
- Latency: with accept at T, mem strobe at T+1.
  - Write: resp_valid at T+3.
  - Read: resp_valid one cycle after the data_ready cycle; minimum T+3.
- No back-to-back grant: IDLE must be re-entered, so the minimum period is 4 cycles per transaction.
- A requester that drops valid before its ready pulse is simply not granted. A requester must not drop valid in the cycle its ready pulses.
- A requester may assert valid again in the cycle after its ready pulse. It is not granted until the arbiter is back in IDLE.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on entry to WAIT_RD.
  - If TIMEOUT_CYCLES cycles elapse without mem_data_ready, go to RESP with resp_err=1 and resp_data=16'hFFFF.
  - A late data_ready is ignored.
- Undefined: resp_err tied 0; WAIT_RD waits indefinitely.

Decomposition:
- Package lisp_mem_pkg: ADDR_W/DATA_W constants, arb_state_t enum (IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP), mem_txn_t struct {we, addr, wdata, id}.
- Sub-module rr_arb2: 2-way round-robin grant with pointer register.

Test Plan:
- Single write: req0 write 16'hBEEF, memory allocates 12'h001 -> req0_ready at T, mem_we at T+1, resp0_valid at T+3 with resp_data=16'h0001, resp_err=0.
- Read with delay: req1 read 12'h002, data_ready 2 cycles after mem_req with 16'hDEAD -> mem_addr=12'h002, resp1_valid once with 16'hDEAD, resp0_valid never.
- Contention: both valid from reset, each issuing 3 writes -> grants alternate 0,1,0,1,0,1; each gets 3 responses.
- Reset in WAIT_RD: assert rst for 1 cycle -> no resp pulse, state IDLE, next grant goes to port 0.
- Idle memory noise: mem_data_ready pulsed while IDLE -> no resp_valid, no state change.
- Timeout (macro on, TIMEOUT_CYCLES=8): read with no data_ready -> resp0_valid 9 cycles after mem_req with resp_err=1, resp_data=16'hFFFF.
